// File: rtl/indicator_pkg.sv
// Shared types and helpers for the bar-graph level meter (indicator_peak_hold).
package indicator_pkg;

   localparam int unsigned DEFAULT_SEGMENTS  = 16;
   localparam int unsigned DEFAULT_POS_WIDTH = 5;
   localparam int unsigned MAX_MASK_WIDTH    = 64;

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_UPDATE  = 1'b1
   } indicator_state_t;

   // Bit k set iff k < level; callers cast down to their segment count.
   function automatic logic [MAX_MASK_WIDTH-1:0] thermo_mask(input int unsigned level);
      logic [MAX_MASK_WIDTH-1:0] mask;
      mask = '0;
      for (int unsigned k = 0; k < MAX_MASK_WIDTH; k++) begin
         mask[k] = (k < level);
      end
      return mask;
   endfunction

endpackage

// File: rtl/indicator_tick_divider.sv
// Display-period prescaler: one-cycle tick every TICK_DIVIDE clocks.
module indicator_tick_divider
   import indicator_pkg::*;
#(
   parameter int unsigned TICK_DIVIDE = 100000
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int unsigned CW = $clog2(TICK_DIVIDE);

   logic [CW-1:0] count;

   assign tick = (count == CW'(TICK_DIVIDE - 1));

   always_ff @(posedge clk) begin
      if (!reset) begin
         count <= '0;
      end else if (tick) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

endmodule

// File: rtl/indicator_peak_hold.sv
// Bar-graph meter: per-period max, decaying bar, peak-hold marker.
// Peak-hold feature enabled by defining INDICATOR_PEAK_HOLD_EN.
module indicator_peak_hold
   import indicator_pkg::*;
#(
   parameter int unsigned SEGMENTS    = DEFAULT_SEGMENTS,
   parameter int unsigned POS_WIDTH   = DEFAULT_POS_WIDTH,
   parameter int unsigned TICK_DIVIDE = 100000,
   parameter int unsigned HOLD_TICKS  = 30
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_valid,
   output logic                 i_ready,
   input  logic [POS_WIDTH-1:0] position,
   output logic                 o_valid,
   input  logic                 o_ready,
   output logic [SEGMENTS-1:0]  bar,
   output logic [POS_WIDTH-1:0] peak
);

   localparam logic [POS_WIDTH-1:0] SEG_MAX = POS_WIDTH'(SEGMENTS);

   indicator_state_t     state, state_next;
   logic                 tick;
   logic                 do_update;
   logic [POS_WIDTH-1:0] clamped;
   logic [POS_WIDTH-1:0] max_in;
   logic [POS_WIDTH-1:0] level, level_next;
   logic [POS_WIDTH-1:0] peak_frame;

   indicator_tick_divider #(
      .TICK_DIVIDE(TICK_DIVIDE)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   always_ff @(posedge clk) begin
      if (!reset) state <= ST_COLLECT;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_COLLECT: if (tick) state_next = ST_UPDATE;
         ST_UPDATE:  state_next = ST_COLLECT;
         default:    state_next = ST_COLLECT;
      endcase
   end

   // i_ready is gated by reset so it reads 0 while reset is held.
   always_comb begin
      i_ready   = 1'b0;
      do_update = 1'b0;
      case (state)
         ST_COLLECT: i_ready   = reset;
         ST_UPDATE:  do_update = 1'b1;
         default:    ;
      endcase
   end

   assign clamped = (position > SEG_MAX) ? SEG_MAX : position;

   always_ff @(posedge clk) begin
      if (!reset) begin
         max_in <= '0;
      end else if (do_update) begin
         max_in <= '0;
      end else if (i_valid && i_ready && (clamped > max_in)) begin
         max_in <= clamped;
      end
   end

   // level - 1 only taken when max_in < level, so it cannot underflow.
   assign level_next = (max_in >= level) ? max_in : level - POS_WIDTH'(1);

   always_ff @(posedge clk) begin
      if (!reset)         level <= '0;
      else if (do_update) level <= level_next;
   end

`ifdef INDICATOR_PEAK_HOLD_EN
   localparam int unsigned HOLD_W = $clog2(HOLD_TICKS + 1);

   logic [POS_WIDTH-1:0] peak_r, peak_next, peak_dec;
   logic [HOLD_W-1:0]    hold_cnt, hold_next;

   assign peak_dec = peak_r - POS_WIDTH'(1);

   always_comb begin
      peak_next = peak_r;
      hold_next = hold_cnt;
      if (level_next >= peak_r) begin
         peak_next = level_next;
         hold_next = HOLD_W'(HOLD_TICKS);
      end else if (hold_cnt != '0) begin
         hold_next = hold_cnt - HOLD_W'(1);
      end else begin
         peak_next = (level_next > peak_dec) ? level_next : peak_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         peak_r   <= '0;
         hold_cnt <= '0;
      end else if (do_update) begin
         peak_r   <= peak_next;
         hold_cnt <= hold_next;
      end
   end

   assign peak_frame = peak_next;
`else
   assign peak_frame = level_next;
`endif

   // A new frame always wins; a same-cycle o_ready retires the old one.
   always_ff @(posedge clk) begin
      if (!reset) begin
         o_valid <= 1'b0;
         bar     <= '0;
         peak    <= '0;
      end else if (do_update) begin
         o_valid <= 1'b1;
         bar     <= SEGMENTS'(thermo_mask(32'(level_next)));
         peak    <= peak_frame;
      end else if (o_valid && o_ready) begin
         o_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_indicator_peak_hold.sv
// Directed-vector bench for indicator_peak_hold (TICK_DIVIDE=8, HOLD_TICKS=3).
module tb_indicator_peak_hold;

   localparam int unsigned SEGMENTS  = 16;
   localparam int unsigned POS_WIDTH = 5;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 i_valid = 1'b0;
   logic                 i_ready;
   logic [POS_WIDTH-1:0] position = '0;
   logic                 o_valid;
   logic                 o_ready = 1'b1;
   logic [SEGMENTS-1:0]  bar;
   logic [POS_WIDTH-1:0] peak;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;

   indicator_peak_hold #(
      .SEGMENTS   (SEGMENTS),
      .POS_WIDTH  (POS_WIDTH),
      .TICK_DIVIDE(8),
      .HOLD_TICKS (3)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .position(position),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .bar     (bar),
      .peak    (peak)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int c);
      while (cyc < c) step();
   endtask

   task automatic send(input int unsigned pos);
      i_valid  = 1'b1;
      position = POS_WIDTH'(pos);
      step();
      i_valid  = 1'b0;
   endtask

   task automatic do_reset();
      reset   = 1'b0;
      i_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_o_valid", 32'(o_valid), 32'd0);
      check("rst_bar",     32'(bar),     32'h0000);
      check("rst_peak",    32'(peak),    32'd0);
      check("rst_i_ready", 32'(i_ready), 32'd0);
      reset = 1'b1;
      cyc   = 0;
      #1;
      check("rel_i_ready", 32'(i_ready), 32'd1);
   endtask

   function automatic logic [31:0] mask_of(input int unsigned lvl);
      logic [31:0] one;
      one = 32'd1;
      return (one << lvl) - 32'd1;
   endfunction

   // Frame n (n >= 1) is visible from cycle 8n+1 after reset release.
   task automatic check_frame(input string tag, input int n, input int unsigned lvl,
                              input int unsigned pk);
      goto(8 * n + 1);
      check({tag, "_valid"}, 32'(o_valid), 32'd1);
      check({tag, "_bar"},   32'(bar),     mask_of(lvl));
      check({tag, "_peak"},  32'(peak),    32'(pk));
   endtask

`ifdef INDICATOR_PEAK_HOLD_EN
   int unsigned pk_single [6] = '{10, 10, 10, 10, 9, 8};
   localparam int unsigned PK_MULTI2 = 12;
   localparam int unsigned PK_ORDY3  = 9;
`else
   int unsigned pk_single [6] = '{10, 9, 8, 7, 6, 5};
   localparam int unsigned PK_MULTI2 = 11;
   localparam int unsigned PK_ORDY3  = 8;
`endif

   initial begin
      // Single sample 10, then silence: bar decays by one per period.
      do_reset();
      send(10);
      for (int n = 1; n <= 6; n++) begin
         check_frame("single", n, 11 - n, pk_single[n-1]);
         if (n == 1) begin
            step();
            check("single_taken", 32'(o_valid), 32'd0);
         end
      end

      // Several samples in one period: frame carries the maximum.
      do_reset();
      send(3);
      send(12);
      send(7);
      check_frame("multi1", 1, 12, 12);
      check("multi1_mask", 32'(bar), 32'h0FFF);
      check_frame("multi2", 2, 11, PK_MULTI2);

      // Clamp plus acceptance on the tick cycle itself.
      do_reset();
      goto(7);
      check("tick_i_ready", 32'(i_ready), 32'd1);
      send(20);
      check("upd_i_ready", 32'(i_ready), 32'd0);
      step();
      check("clamp_bar",  32'(bar),  32'hFFFF);
      check("clamp_peak", 32'(peak), 32'd16);
      check("post_i_ready", 32'(i_ready), 32'd1);

      // Back-pressure across three updates: latest frame wins.
      o_ready = 1'b0;
      do_reset();
      send(5);
      goto(10);
      send(9);
      check("bp_pending", 32'(o_valid), 32'd1);
      goto(18);
      send(2);
      check_frame("bp3", 3, 8, PK_ORDY3);
      o_ready = 1'b1;
      step();
      o_ready = 1'b0;
      check("bp_drop", 32'(o_valid), 32'd0);
      step();
      check("bp_stay_low", 32'(o_valid), 32'd0);

      // Reset with a pending frame and pending max_in discards both.
      send(10);
      goto(30);
      send(14);
      do_reset();
      goto(9);
      check("discard_valid", 32'(o_valid), 32'd1);
      check("discard_bar",   32'(bar),     32'h0000);
      check("discard_peak",  32'(peak),    32'd0);
      o_ready = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
